// File: rtl/multi_edge_detector.sv
// multi_edge_detector
//   Multi-channel edge detector for raw asynchronous inputs. Each channel goes
//   through a synchroniser chain and a glitch filter. A qualified change of the
//   filtered level raises a one-cycle pulse and sets a sticky event flag. The
//   sticky flags, gated by per-channel enables, form a single interrupt.
//
// Ports
//   clk          : clock, all flops on rising edge
//   reset        : asynchronous active-low reset
//   signal       : raw asynchronous inputs, one bit per channel
//   mode         : per channel [2i+1:2i] 00 off, 01 rising, 10 falling, 11 both
//   irq_en       : per-channel interrupt enable
//   clear        : per-channel sticky clear, sampled every clock
//   level        : filtered, synchronised input level
//   edge_pulse   : one-cycle pulse per qualified level change
//   event_sticky : latched edge events
//   irq          : OR of (event_sticky & irq_en)
module multi_edge_detector #(
  parameter int CHANNELS      = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   signal,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   irq_en,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   edge_pulse,
  output logic [CHANNELS-1:0]   event_sticky,
  output logic                  irq
);

  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [CHANNELS-1:0] sync_p0 [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_out;

  logic [CNT_W-1:0]    cnt_p1  [CHANNELS];
  logic [CNT_W-1:0]    cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] level_p1;
  logic [CHANNELS-1:0] level_nxt;

  logic [CHANNELS-1:0] pulse_nxt;
  logic [CHANNELS-1:0] pulse_p2;
  logic [CHANNELS-1:0] sticky_p2;

  // Stage 0: synchroniser chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p0[s] <= '0;
    end else begin
      sync_p0[0] <= signal;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p0[s] <= sync_p0[s-1];
    end
  end

  assign sync_out = sync_p0[SYNC_STAGES-1];

  // Filter decision and edge qualification. The level flips only after the
  // synchronised value has disagreed with it for FILTER_CYCLES consecutive
  // cycles; any agreement restarts the count. mode is looked at only on the
  // cycle the flip happens.
  always_comb begin
    level_nxt = level_p1;
    pulse_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nxt[i] = cnt_p1[i];
      if (sync_out[i] == level_p1[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt_p1[i] == CNT_LAST) begin
        cnt_nxt[i]   = '0;
        level_nxt[i] = sync_out[i];
        pulse_nxt[i] = sync_out[i] ? mode[2*i] : mode[2*i+1];
      end else begin
        cnt_nxt[i] = cnt_p1[i] + CNT_W'(1);
      end
    end
  end

  // Stage 1: filter counters and filtered level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_p1 <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt_p1[i] <= '0;
    end else begin
      level_p1 <= level_nxt;
      for (int i = 0; i < CHANNELS; i++) cnt_p1[i] <= cnt_nxt[i];
    end
  end

  // Stage 2: edge pulse and sticky event flags. A new edge wins over a
  // simultaneous clear so that no event is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse_p2  <= '0;
      sticky_p2 <= '0;
    end else begin
      pulse_p2  <= pulse_nxt;
      sticky_p2 <= (sticky_p2 & ~clear) | pulse_nxt;
    end
  end

  assign level        = level_p1;
  assign edge_pulse   = pulse_p2;
  assign event_sticky = sticky_p2;
  assign irq          = |(sticky_p2 & irq_en);

endmodule

// File: tb/tb_multi_edge_detector.sv
module tb_multi_edge_detector;

  logic        clk;
  logic        reset;
  logic [7:0]  signal;
  logic [15:0] mode;
  logic [7:0]  irq_en;
  logic [7:0]  clear;

  logic [7:0]  level_a, pulse_a, sticky_a;
  logic        irq_a;
  logic [7:0]  level_b, pulse_b, sticky_b;
  logic        irq_b;

  int n_checks = 0;
  int n_fail   = 0;

  multi_edge_detector #(.CHANNELS(8), .SYNC_STAGES(2), .FILTER_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .signal(signal), .mode(mode), .irq_en(irq_en),
    .clear(clear), .level(level_a), .edge_pulse(pulse_a),
    .event_sticky(sticky_a), .irq(irq_a)
  );

  multi_edge_detector #(.CHANNELS(8), .SYNC_STAGES(3), .FILTER_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .signal(signal), .mode(mode), .irq_en(irq_en),
    .clear(clear), .level(level_b), .edge_pulse(pulse_b),
    .event_sticky(sticky_b), .irq(irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, falls;
    logic seen;

    reset  = 1'b0;
    signal = 8'hFF;
    mode   = 16'h0001;
    irq_en = 8'h00;
    clear  = 8'h00;

    // Reset with inputs high
    repeat (4) tick();
    check_eq("rst_level",  32'(level_a),  32'h00);
    check_eq("rst_pulse",  32'(pulse_a),  32'h00);
    check_eq("rst_sticky", 32'(sticky_a), 32'h00);
    check_eq("rst_irq",    32'(irq_a),    32'h0);

    reset = 1'b1;
    repeat (5) tick();
    check_eq("rel_pulse_e4", 32'(pulse_a), 32'h00);
    check_eq("rel_level_e4", 32'(level_a), 32'h00);
    tick();
    check_eq("rel_level_e5",  32'(level_a),  32'hFF);
    check_eq("rel_pulse_e5",  32'(pulse_a),  32'h01);
    check_eq("rel_sticky_e5", 32'(sticky_a), 32'h01);
    tick();
    check_eq("rel_pulse_e6",  32'(pulse_a),  32'h00);
    check_eq("rel_sticky_e6", 32'(sticky_a), 32'h01);
    check_eq("rel_irq_off",   32'(irq_a),    32'h0);

    // Return everything to idle
    mode   = 16'h0000;
    signal = 8'h00;
    clear  = 8'hFF;
    repeat (10) tick();
    clear  = 8'h00;
    check_eq("idle_level",  32'(level_a),  32'h00);
    check_eq("idle_sticky", 32'(sticky_a), 32'h00);

    // Mode latency: ch1 rise, ch2 fall, ch3 both, ch4 off
    mode   = 16'h00E4;
    signal = 8'h1E;
    repeat (3) tick();
    check_eq("b_rise_e2", 32'(pulse_b), 32'h00);
    tick();
    check_eq("b_rise_e3", 32'(pulse_b), 32'h0A);
    tick();
    check_eq("mode_rise_e4",   32'(pulse_a), 32'h00);
    check_eq("b_rise_e4",      32'(pulse_b), 32'h00);
    tick();
    check_eq("mode_rise_e5",   32'(pulse_a),  32'h0A);
    check_eq("mode_rise_lvl",  32'(level_a),  32'h1E);
    check_eq("mode_rise_stk",  32'(sticky_a), 32'h0A);
    tick();
    check_eq("mode_rise_e6",   32'(pulse_a), 32'h00);
    repeat (13) tick();
    signal = 8'h00;
    repeat (3) tick();
    check_eq("b_fall_e2", 32'(pulse_b), 32'h00);
    tick();
    check_eq("b_fall_e3", 32'(pulse_b), 32'h0C);
    repeat (2) tick();
    check_eq("mode_fall_e5",  32'(pulse_a),  32'h0C);
    check_eq("mode_fall_lvl", 32'(level_a),  32'h00);
    check_eq("mode_fall_stk", 32'(sticky_a), 32'h0E);
    clear = 8'hFF;
    tick();
    clear = 8'h00;
    check_eq("clear_all", 32'(sticky_a), 32'h00);

    // Glitch filter on ch0: 3 cycles high is rejected
    mode      = 16'h0003;
    signal[0] = 1'b1;
    seen      = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 2) signal[0] = 1'b0;
      seen = seen | pulse_a[0] | level_a[0];
    end
    check_eq("glitch3_quiet", 32'(seen), 32'h0);

    // 4 cycles high passes: one rise, then one fall
    rises     = 0;
    falls     = 0;
    signal[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 3) signal[0] = 1'b0;
      if (pulse_a[0] &&  level_a[0]) rises++;
      if (pulse_a[0] && !level_a[0]) falls++;
    end
    check_eq("glitch4_rises", 32'(rises), 32'd1);
    check_eq("glitch4_falls", 32'(falls), 32'd1);

    // Clear racing a new edge on ch0
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    check_eq("race_pre_clear", 32'(sticky_a[0]), 32'h0);
    signal[0] = 1'b1;
    repeat (5) tick();
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    check_eq("race_pulse",  32'(pulse_a[0]),  32'h1);
    check_eq("race_sticky", 32'(sticky_a[0]), 32'h1);
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    check_eq("race_clear2", 32'(sticky_a[0]), 32'h0);
    signal[0] = 1'b0;
    repeat (10) tick();
    clear = 8'hFF;
    tick();
    clear = 8'h00;

    // irq masking with events on ch5 and ch6
    mode   = 16'h1400;
    irq_en = 8'h00;
    signal = 8'h60;
    repeat (8) tick();
    check_eq("irq_evts",   32'(sticky_a), 32'h60);
    check_eq("irq_masked", 32'(irq_a),    32'h0);
    irq_en = 8'h40;
    #1;
    check_eq("irq_unmask", 32'(irq_a),    32'h1);
    check_eq("irq_stk_kept", 32'(sticky_a), 32'h60);
    clear[6] = 1'b1;
    tick();
    clear[6] = 1'b0;
    check_eq("irq_cleared", 32'(irq_a),    32'h0);
    check_eq("irq_ch5_kept", 32'(sticky_a), 32'h20);
    irq_en = 8'h00;
    clear  = 8'hFF;
    tick();
    clear  = 8'h00;

    // Reset in the middle of a ch7 rise
    mode      = 16'h4000;
    signal[7] = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check_eq("mid_rst_level",  32'(level_a),  32'h00);
    check_eq("mid_rst_pulse",  32'(pulse_a),  32'h00);
    check_eq("mid_rst_sticky", 32'(sticky_a), 32'h00);
    check_eq("mid_rst_irq",    32'(irq_a),    32'h0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen = seen | (|pulse_a) | (|level_a);
    end
    check_eq("mid_rst_hold", 32'(seen), 32'h0);
    reset = 1'b1;
    repeat (5) tick();
    check_eq("post_rst_e4", 32'(pulse_a), 32'h00);
    tick();
    check_eq("post_rst_pulse",  32'(pulse_a),  32'h80);
    check_eq("post_rst_level",  32'(level_a),  32'hE0);
    check_eq("post_rst_sticky", 32'(sticky_a), 32'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
